adder_sweep_checker: RTL and testbench

Synthesizable self-test engine for the ripple full-adder family: exhaustively sweeps every {C_in, B, A} combination into the adder under test, waits a programmable settle time, and compares the adder's {C_out, S} against an internally computed reference sum. It is the on-chip response side of the adder stimulus/response interface, replacing the simulation-only sweep bench with hardware that reports pass/fail, error count and the first failing vector. It sits beside each adder instance in the arbiter datapath and is run from the bring-up controller.

---
 rtl/adder_sweep_checker.sv | 144 ++++++++++++++
 tb/tb_adder_sweep_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive {cin, b, a} sweep of a ripple adder, compared against a reference sum.
// Build macro ADDER_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module adder_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 cin_o,
  input  logic [WIDTH-1:0]     s_i,
  input  logic                 cout_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_cnt,
  output logic [2*WIDTH:0]     first_fail,
  output logic [2:0]           state_o
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam logic [EW-1:0] ERR_MAX  = '1;
  localparam logic [3:0]    SETTLE_L = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [EW-1:0]    err_q, err_d;
  logic [VW-1:0]    ff_q, ff_d;
  logic [WIDTH:0]   ref_sum;
  logic             mismatch;
  logic             stop_now;

  // Reference is built from the registered operands, so it matches exactly what the adder sees.
  assign ref_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign mismatch = (ref_sum != {cout_i, s_i});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ff_d     = ff_q;
    stop_now = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
        end
      end
      S_DRIVE: begin
        // Operands land on the edge leaving DRIVE; they stay put until the next DRIVE.
        a_d   = vec_q[WIDTH-1:0];
        b_d   = vec_q[2*WIDTH-1:WIDTH];
        cin_d = vec_q[2*WIDTH];
        cnt_d = SETTLE_L;
        state_d = (SETTLE == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q == '0) begin
            ff_d = vec_q;
          end
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
`ifdef ADDER_SWEEP_STOP_ON_FAIL_EN
          stop_now = 1'b1;
`else
          stop_now = 1'b0;
`endif
        end
        if (stop_now || (vec_q == VEC_LAST)) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign cin_o      = cin_q;
  assign busy       = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_q == '0);
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: three instances (2/2 clean or cout-stuck, 1/0 with S inverted, 2/0 restart).
// Expected sweep results are queued at each start; a monitor pops them when done rises.
module tb_adder_sweep_checker;

`ifdef ADDER_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start0, start1, start2, stuck0;
  int   n_cmp = 0;
  int   n_err = 0;

  // u0: WIDTH=2, SETTLE=2, optional cout stuck at 0
  logic [1:0] a0, b0, s0;
  logic       cin0, cout0, busy0, done0, pass0;
  logic [5:0] err0;
  logic [4:0] ff0;
  logic [2:0] st0;
  logic [2:0] sum0;
  assign sum0  = {1'b0, a0} + {1'b0, b0} + {2'b00, cin0};
  assign s0    = sum0[1:0];
  assign cout0 = stuck0 ? 1'b0 : sum0[2];

  // u1: WIDTH=1, SETTLE=0, sum bit 0 inverted
  logic       a1, b1, s1, cin1, cout1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ff1;
  logic [2:0] st1;
  logic [1:0] sum1;
  assign sum1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
  assign s1    = ~sum1[0];
  assign cout1 = sum1[1];

  // u2: WIDTH=2, SETTLE=0, correct adder
  logic [1:0] a2, b2, s2;
  logic       cin2, cout2, busy2, done2, pass2;
  logic [5:0] err2;
  logic [4:0] ff2;
  logic [2:0] st2;
  logic [2:0] sum2;
  assign sum2  = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
  assign s2    = sum2[1:0];
  assign cout2 = sum2[2];

  adder_sweep_checker #(.WIDTH(2), .SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0), .cin_o(cin0),
    .s_i(s0), .cout_i(cout0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail(ff0), .state_o(st0));

  adder_sweep_checker #(.WIDTH(1), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_o(a1), .b_o(b1), .cin_o(cin1),
    .s_i(s1), .cout_i(cout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail(ff1), .state_o(st1));

  adder_sweep_checker #(.WIDTH(2), .SETTLE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_o(a2), .b_o(b2), .cin_o(cin2),
    .s_i(s2), .cout_i(cout2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail(ff2), .state_o(st2));

  // scoreboard: {latency[15:0], pass, err_cnt[7:0], first_fail[7:0]}
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q2[$];
  int   t_busy[3]   = '{0, 0, 0};
  int   done_cnt[3] = '{0, 0, 0};
  logic busy_p[3]   = '{1'b0, 1'b0, 1'b0};
  logic done_p[3]   = '{1'b0, 1'b0, 1'b0};
  logic step_busy_p = 1'b0;
  int   step_idx    = 0;

  function automatic logic [32:0] pk(input int lat, input bit p, input int e, input int f);
    return {16'(lat), p, 8'(e), 8'(f)};
  endfunction

  task automatic mon(input int u, input logic bz, input logic dn, input logic ps,
                     input logic [7:0] er, input logic [7:0] ff);
    logic [32:0] got, want;
    bit have;
    if (bz && !busy_p[u]) t_busy[u] = cyc;
    if (dn && !done_p[u]) begin
      got  = {16'(cyc - t_busy[u]), ps, er, ff};
      have = 1'b0;
      want = '0;
      case (u)
        0: if (exp_q0.size() > 0) begin want = exp_q0.pop_front(); have = 1'b1; end
        1: if (exp_q1.size() > 0) begin want = exp_q1.pop_front(); have = 1'b1; end
        default: if (exp_q2.size() > 0) begin want = exp_q2.pop_front(); have = 1'b1; end
      endcase
      n_cmp++;
      if (!have || (got != want) || bz) begin
        n_err++;
        $display("FAIL done_u%0d got lat=%0d pass=%0b err=%0d ff=%0d busy=%0b, expected lat=%0d pass=%0b err=%0d ff=%0d busy=0 queued=%0b",
                 u, got[32:17], got[16], got[15:8], got[7:0], bz,
                 want[32:17], want[16], want[15:8], want[7:0], have);
      end
      done_cnt[u]++;
    end
    busy_p[u] = bz;
    done_p[u] = dn;
  endtask

  // monitor: sweep results on done, operand order on every u0 CHECK cycle
  always @(negedge clk) begin
    mon(0, busy0, done0, pass0, 8'(err0), 8'(ff0));
    mon(1, busy1, done1, pass1, 8'(err1), 8'(ff1));
    mon(2, busy2, done2, pass2, 8'(err2), 8'(ff2));
    if (busy0 && !step_busy_p) step_idx = 0;
    step_busy_p = busy0;
    if (st0 == 3'd3) begin
      n_cmp++;
      if ({cin0, b0, a0} != 5'(step_idx)) begin
        n_err++;
        $display("FAIL step_u0 got {cin,b,a}=%0d expected %0d", {cin0, b0, a0}, step_idx);
      end
      step_idx++;
    end
  end

  // driver tasks
  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_reset_u0(input string tag);
    chk({tag, "_a"},     int'(a0),    0);
    chk({tag, "_b"},     int'(b0),    0);
    chk({tag, "_cin"},   int'(cin0),  0);
    chk({tag, "_busy"},  int'(busy0), 0);
    chk({tag, "_done"},  int'(done0), 0);
    chk({tag, "_pass"},  int'(pass0), 0);
    chk({tag, "_err"},   int'(err0),  0);
    chk({tag, "_ff"},    int'(ff0),   0);
    chk({tag, "_state"}, int'(st0),   0);
  endtask

  task automatic set_start(input int u, input logic v);
    case (u)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic pulse(input int u);
    @(negedge clk); #1;
    set_start(u, 1'b1);
    @(negedge clk); #1;
    set_start(u, 1'b0);
  endtask

  task automatic wait_done(input int u, input int target, input int budget);
    int n = 0;
    while ((done_cnt[u] < target) && (n < budget)) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (done_cnt[u] < target) begin
      n_err++;
      $display("FAIL timeout_u%0d got %0d done events expected %0d within %0d cycles",
               u, done_cnt[u], target, budget);
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; stuck0 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_reset_u0("reset");

    // clean sweep, WIDTH=2 SETTLE=2: 32 vectors * 4 cycles
    exp_q0.push_back(pk(128, 1'b1, 0, 0));
    pulse(0);
    wait_done(0, 1, 400);
    chk("clean_hold_a",   int'(a0),   3);
    chk("clean_hold_b",   int'(b0),   3);
    chk("clean_hold_cin", int'(cin0), 1);

    // cout stuck at 0: first failure is A=3 B=1 Cin=0 (vector 7), 16 failures in total
    stuck0 = 1'b1;
    exp_q0.push_back(pk(STOP ? 32 : 128, 1'b0, STOP ? 1 : 16, 7));
    pulse(0);
    wait_done(0, 2, 400);
    chk("stuck_hold_a",   int'(a0),   3);
    chk("stuck_hold_b",   int'(b0),   STOP ? 1 : 3);
    chk("stuck_hold_cin", int'(cin0), STOP ? 0 : 1);

    // reset on the 50th edge of a sweep, then a clean rerun with stray start pulses mid-sweep
    stuck0 = 1'b0;
    pulse(0);
    repeat (49) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk_reset_u0("midreset");
    rst_n = 1'b1;
    exp_q0.push_back(pk(128, 1'b1, 0, 0));
    pulse(0);
    repeat (30) @(negedge clk);
    #1 start0 = 1'b1;
    repeat (5) @(negedge clk);
    #1 start0 = 1'b0;
    wait_done(0, 3, 400);

    // WIDTH=1 SETTLE=0 with inverted sum bit: every vector fails
    exp_q1.push_back(pk(STOP ? 2 : 16, 1'b0, STOP ? 1 : 8, 0));
    pulse(1);
    wait_done(1, 1, 100);

    // start held high: back-to-back 64-cycle sweeps restarting from DONE
    exp_q2.push_back(pk(64, 1'b1, 0, 0));
    exp_q2.push_back(pk(64, 1'b1, 0, 0));
    @(negedge clk); #1 start2 = 1'b1;
    wait_done(2, 2, 400);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("held_done",  int'(done2), 1);
    chk("held_busy",  int'(busy2), 0);
    chk("held_pass",  int'(pass2), 1);
    chk("held_count", done_cnt[2], 2);

    repeat (3) @(negedge clk);
    chk("queues_empty", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
